// File: rtl/evt_timestamp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : evt_timestamp_fifo
// Purpose  : Stamps arbiter-granted pixel events with a free-running cycle
//            timestamp and buffers the packed words in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module evt_timestamp_fifo #(
    parameter int ROW_ADD  = 5,
    parameter int COL_ADD  = 5,
    parameter int POLARITY = 2,
    parameter int SIZE     = 32,
    parameter int WIDTH    = 43,
    parameter int DEPTH    = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       evt_valid_i,
    input  logic [ROW_ADD-1:0]         evt_row_i,
    input  logic [COL_ADD-1:0]         evt_col_i,
    input  logic [POLARITY-1:0]        evt_pol_i,
    output logic                       evt_ready_o,
    output logic [WIDTH-1:0]           data_o,
    output logic                       data_valid_o,
    input  logic                       data_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       pol_err_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [SIZE-1:0]   r_ts;
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [15:0]       r_drop_cnt;
    logic              r_pol_err;

    logic              w_full;
    logic              w_empty;
    logic              w_pol_ok;
    logic              w_push;
    logic              w_pop;
    logic [WIDTH-1:0]  w_word;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_pol_ok = (evt_pol_i == POLARITY'(1)) || (evt_pol_i == POLARITY'(2));
    assign w_push   = evt_valid_i && w_pol_ok && !w_full;
    assign w_pop    = !w_empty && data_ready_i;
    assign w_word   = {r_ts, evt_row_i, evt_col_i, (evt_pol_i == POLARITY'(1))};

    assign evt_ready_o  = !w_full;
    assign data_valid_o = !w_empty;
    assign data_o       = r_mem[r_rd_ptr[c_AW-1:0]];
    assign count_o      = r_wr_ptr - r_rd_ptr;
    assign drop_cnt_o   = r_drop_cnt;
    assign pol_err_o    = r_pol_err;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
            r_pol_err  <= 1'b0;
        end else begin
            r_ts      <= r_ts + 1'b1;
            r_pol_err <= evt_valid_i && !w_pol_ok;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A valid event arriving while full is lost even if a pop frees a slot this cycle.
            if (evt_valid_i && w_pol_ok && w_full && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_evt_timestamp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_evt_timestamp_fifo
// Purpose  : Directed scoreboard bench for evt_timestamp_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evt_timestamp_fifo;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        evt_valid_i;
    logic [4:0]  evt_row_i;
    logic [4:0]  evt_col_i;
    logic [1:0]  evt_pol_i;
    logic        evt_ready_o;
    logic [42:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic [4:0]  count_o;
    logic [15:0] drop_cnt_o;
    logic        pol_err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [42:0] q_exp [$];
    logic [31:0] m_ts;

    evt_timestamp_fifo dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .evt_valid_i  (evt_valid_i),
        .evt_row_i    (evt_row_i),
        .evt_col_i    (evt_col_i),
        .evt_pol_i    (evt_pol_i),
        .evt_ready_o  (evt_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .count_o      (count_o),
        .drop_cnt_o   (drop_cnt_o),
        .pol_err_o    (pol_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference cycle counter mirroring the timestamp definition.
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) m_ts <= '0;
        else          m_ts <= m_ts + 1;
    end

    // Monitor: every word handed over must match the oldest expected word.
    always @(negedge clk_i) begin
        if (reset_i && data_valid_o && data_ready_i) begin
            n_cmp++;
            if (q_exp.size() == 0) begin
                n_err++;
                $display("FAIL word: got %h, required none (queue empty)", data_o);
            end else begin
                logic [42:0] exp_w;
                exp_w = q_exp.pop_front();
                if (data_o !== exp_w) begin
                    n_err++;
                    $display("FAIL word: got %h, required %h", data_o, exp_w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [4:0] row, input logic [4:0] col, input logic [1:0] pol,
                         input bit push, input logic [31:0] ts);
        evt_valid_i = 1'b1;
        evt_row_i   = row;
        evt_col_i   = col;
        evt_pol_i   = pol;
        if (push) q_exp.push_back({ts, row, col, (pol == 2'b01)});
    endtask

    task automatic idle();
        evt_valid_i = 1'b0;
        evt_pol_i   = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset_i      = 1'b0;
        data_ready_i = 1'b0;
        evt_row_i    = '0;
        evt_col_i    = '0;
        idle();
        repeat (3) tick();
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(data_valid_o), 64'd0);
        check("rst_ready", 64'(evt_ready_o), 64'd1);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_polerr", 64'(pol_err_o), 64'd0);
        reset_i = 1'b1;

        // Single ON event at cycle 10
        g = 0;
        while (m_ts != 32'd10 && g < 50) begin tick(); g++; end
        drive(5'd3, 5'd17, 2'b01, 1'b1, 32'd10);
        tick();
        idle();
        check("lat_valid", 64'(data_valid_o), 64'd1);
        check("lat_count", 64'(count_o), 64'd1);
        data_ready_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
        check("pop_count", 64'(count_o), 64'd0);

        // Fill with 16 OFF events, then two more that must be dropped
        for (int i = 0; i < 16; i++) begin
            drive(5'(i), 5'(31 - i), 2'b10, 1'b1, m_ts);
            tick();
        end
        check("full_count", 64'(count_o), 64'd16);
        check("full_ready", 64'(evt_ready_o), 64'd0);
        drive(5'd20, 5'd20, 2'b10, 1'b0, m_ts);
        tick();
        drive(5'd21, 5'd21, 2'b01, 1'b0, m_ts);
        tick();
        idle();
        check("drop2", 64'(drop_cnt_o), 64'd2);

        // Push and pop together while full: push lost, pop proceeds
        drive(5'd1, 5'd1, 2'b01, 1'b0, m_ts);
        data_ready_i = 1'b1;
        tick();
        idle();
        data_ready_i = 1'b0;
        check("fullpp_drop", 64'(drop_cnt_o), 64'd3);
        check("fullpp_count", 64'(count_o), 64'd15);

        data_ready_i = 1'b1;
        g = 0;
        while (count_o != 0 && g < 40) begin tick(); g++; end
        data_ready_i = 1'b0;
        check("drain_count", 64'(count_o), 64'd0);
        check("drain_queue", 64'(q_exp.size()), 64'd0);

        // Invalid polarities
        drive(5'd2, 5'd5, 2'b01, 1'b1, m_ts);
        tick();
        idle();
        check("pe_pre_count", 64'(count_o), 64'd1);
        drive(5'd7, 5'd7, 2'b11, 1'b0, m_ts);
        tick();
        idle();
        check("pe11_pulse", 64'(pol_err_o), 64'd1);
        check("pe11_count", 64'(count_o), 64'd1);
        check("pe11_drop", 64'(drop_cnt_o), 64'd3);
        tick();
        check("pe_clear", 64'(pol_err_o), 64'd0);
        drive(5'd8, 5'd8, 2'b00, 1'b0, m_ts);
        tick();
        idle();
        check("pe00_pulse", 64'(pol_err_o), 64'd1);
        check("pe00_count", 64'(count_o), 64'd1);
        check("pe00_drop", 64'(drop_cnt_o), 64'd3);

        // Sustained push+pop keeps occupancy steady
        data_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(5'(10 + i), 5'(i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, m_ts);
            tick();
            check("tp_count", 64'(count_o), 64'd1);
        end
        idle();
        tick();
        data_ready_i = 1'b0;
        check("tp_drain", 64'(count_o), 64'd0);

        // Timestamp wrap
        force dut.r_ts = 32'hFFFF_FFFF;
        #1;
        release dut.r_ts;
        drive(5'd4, 5'd4, 2'b01, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(5'd4, 5'd5, 2'b10, 1'b1, 32'h0000_0000);
        tick();
        idle();
        check("wrap_count", 64'(count_o), 64'd2);
        data_ready_i = 1'b1;
        tick();
        tick();
        data_ready_i = 1'b0;
        check("wrap_drain", 64'(count_o), 64'd0);

        // Reset mid-operation flushes buffered events
        for (int i = 0; i < 8; i++) begin
            drive(5'(i), 5'(i), 2'b01, 1'b1, m_ts);
            tick();
        end
        idle();
        check("mid_count", 64'(count_o), 64'd8);
        #3;
        reset_i = 1'b0;
        #1;
        q_exp.delete();
        check("mr_count", 64'(count_o), 64'd0);
        check("mr_valid", 64'(data_valid_o), 64'd0);
        check("mr_ready", 64'(evt_ready_o), 64'd1);
        check("mr_drop", 64'(drop_cnt_o), 64'd0);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        tick();
        drive(5'd9, 5'd9, 2'b01, 1'b1, 32'd2);
        tick();
        idle();
        check("post_count", 64'(count_o), 64'd1);
        data_ready_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
        tick();
        check("post_drain", 64'(count_o), 64'd0);
        check("post_queue", 64'(q_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
